// File: rtl/riscv_sim_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_sim_monitor_pkg
// Brief    : Shared types and constants for the riscv simulation monitor:
//            run-control FSM encoding and the CSR status word meaning "pass".
// Revision : 1.0 - initial release
// ============================================================================
package riscv_sim_monitor_pkg;

    // Run-control states; encodings are shared with host-side tooling
    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mon_state_t;

    // A core reports success by writing exactly this value to its status CSR
    localparam int unsigned c_STATUS_PASS = 1;

    // Width of the core-index fields (fail_core, stat_sel)
    localparam int unsigned c_CORE_IDX_W = 3;

endpackage
`default_nettype wire

// File: rtl/riscv_sim_core_tracker.sv
`default_nettype none
// ============================================================================
// Module   : riscv_sim_core_tracker
// Brief    : Per-core bookkeeping: retired-instruction counter, first nonzero
//            CSR status latch and finished flag. Also exposes the values the
//            latch/flag will hold after this edge so the parent can form its
//            verdict on the same edge the last core finishes.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_sim_core_tracker
    import riscv_sim_monitor_pkg::*;
#(
    parameter int P_CNT_SZ    = 32,
    parameter int P_STATUS_SZ = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_run,
    input  logic                   i_commit,
    input  logic [P_STATUS_SZ-1:0] i_status,
    output logic [P_CNT_SZ-1:0]    o_inst_count,
    output logic [P_STATUS_SZ-1:0] o_status,
    output logic                   o_finished,
    output logic [P_STATUS_SZ-1:0] o_status_next,
    output logic                   o_finished_next
);

    logic [P_CNT_SZ-1:0]    r_inst_count;
    logic [P_STATUS_SZ-1:0] r_status;
    logic                   r_finished;
    logic                   w_active;
    logic                   w_seen;

    // Only a running, not-yet-finished core is tracked
    assign w_active = i_run & ~r_finished;
    assign w_seen   = w_active & (i_status != '0);

    // Count commits (including one coincident with the status write) and latch the first nonzero status
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_inst_count <= '0;
            r_status     <= '0;
            r_finished   <= 1'b0;
        end else begin
            if (w_active && i_commit && (r_inst_count != '1)) begin
                r_inst_count <= r_inst_count + P_CNT_SZ'(1);
            end
            if (w_seen) begin
                r_status   <= i_status;
                r_finished <= 1'b1;
            end
        end
    end

    assign o_inst_count    = r_inst_count;
    assign o_status        = r_status;
    assign o_finished      = r_finished;
    assign o_status_next   = w_seen ? i_status : r_status;
    assign o_finished_next = r_finished | w_seen;

endmodule
`default_nettype wire

// File: rtl/riscv_sim_monitor.sv
`default_nettype none
// ============================================================================
// Module   : riscv_sim_monitor
// Brief    : Run-control and statistics monitor for 1..8 riscv cores. Staged
//            downstream reset release, RUN-cycle counting, per-core tracking,
//            pass/fail/timeout verdict and a host stats readout mux.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_sim_monitor
    import riscv_sim_monitor_pkg::*;
#(
    parameter int P_NUM_CORES  = 1,
    parameter int P_CNT_SZ     = 32,
    parameter int P_STATUS_SZ  = 32,
    parameter int P_RST_STAGES = 2
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [P_CNT_SZ-1:0]                max_cycles,
    input  logic [P_NUM_CORES*P_STATUS_SZ-1:0] core_status,
    input  logic [P_NUM_CORES-1:0]             inst_commit,
    output logic [P_RST_STAGES-1:0]            rst_out,
    output logic                               running,
    output logic                               done,
    output logic                               pass,
    output logic                               fail,
    output logic                               timeout,
    output logic [c_CORE_IDX_W-1:0]            fail_core,
    output logic [P_STATUS_SZ-1:0]             fail_status,
    input  logic [c_CORE_IDX_W-1:0]            stat_sel,
    output logic [P_CNT_SZ-1:0]                stat_cycles,
    output logic [P_CNT_SZ-1:0]                stat_inst,
    output logic [P_STATUS_SZ-1:0]             stat_status
);

    localparam logic [P_STATUS_SZ-1:0] c_PASS_WORD = P_STATUS_SZ'(c_STATUS_PASS);

    mon_state_t                  r_state;
    mon_state_t                  w_state_next;
    logic [P_RST_STAGES-1:0]     r_rst_chain;
    logic [P_CNT_SZ-1:0]         r_cycles;
    logic                        r_done;
    logic                        r_pass;
    logic                        r_fail;
    logic                        r_timeout;
    logic [c_CORE_IDX_W-1:0]     r_fail_core;
    logic [P_STATUS_SZ-1:0]      r_fail_status;

    logic                        w_run;
    logic                        w_all_fin_next;
    logic                        w_timeout_hit;
    logic                        w_go_done;
    logic                        w_fail;
    logic                        w_all_pass;
    logic [c_CORE_IDX_W-1:0]     w_fail_core;
    logic [P_STATUS_SZ-1:0]      w_fail_status;

    logic [P_CNT_SZ-1:0]         w_inst   [P_NUM_CORES];
    logic [P_STATUS_SZ-1:0]      w_status [P_NUM_CORES];
    logic [P_STATUS_SZ-1:0]      w_status_next [P_NUM_CORES];
    logic [P_NUM_CORES-1:0]      w_fin;
    logic [P_NUM_CORES-1:0]      w_fin_next;

    assign w_run = (r_state == S_RUN);

    // Staged reset release: memory stage first, each later stage one cycle behind
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rst_chain <= '1;
        end else begin
            r_rst_chain <= {r_rst_chain[P_RST_STAGES-2:0], 1'b0};
        end
    end

    // One tracker per monitored core
    for (genvar gi = 0; gi < P_NUM_CORES; gi++) begin : g_core
        riscv_sim_core_tracker #(
            .P_CNT_SZ    (P_CNT_SZ),
            .P_STATUS_SZ (P_STATUS_SZ)
        ) u_tracker (
            .clk             (clk),
            .reset_n         (reset_n),
            .i_run           (w_run),
            .i_commit        (inst_commit[gi]),
            .i_status        (core_status[gi*P_STATUS_SZ +: P_STATUS_SZ]),
            .o_inst_count    (w_inst[gi]),
            .o_status        (w_status[gi]),
            .o_finished      (w_fin[gi]),
            .o_status_next   (w_status_next[gi]),
            .o_finished_next (w_fin_next[gi])
        );
    end

    // Completion is judged on post-edge values so done follows the last status by one cycle;
    // completion in the same cycle as the limit suppresses the timeout
    assign w_all_fin_next = &w_fin_next;
    assign w_timeout_hit  = w_run && (max_cycles != '0) && (r_cycles == max_cycles) && !w_all_fin_next;
    assign w_go_done      = w_run && (w_all_fin_next || w_timeout_hit);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; DONE is left only through reset
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RST:   if (!r_rst_chain[P_RST_STAGES-1]) w_state_next = S_RUN;
            S_RUN:   if (w_go_done) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_DONE;
            default: w_state_next = S_RST;
        endcase
    end

    // RUN-cycle counter; the cycle that trips the timeout is not counted so the count equals the limit
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cycles <= '0;
        end else if (w_run && !w_timeout_hit && (r_cycles != '1)) begin
            r_cycles <= r_cycles + P_CNT_SZ'(1);
        end
    end

    // Verdict reduction over post-edge statuses; descending scan leaves the lowest failing index
    always_comb begin
        w_fail        = 1'b0;
        w_all_pass    = 1'b1;
        w_fail_core   = '0;
        w_fail_status = '0;
        for (int i = P_NUM_CORES - 1; i >= 0; i--) begin
            if (w_status_next[i] > c_PASS_WORD) begin
                w_fail        = 1'b1;
                w_fail_core   = c_CORE_IDX_W'(i);
                w_fail_status = w_status_next[i];
            end
            if (w_status_next[i] != c_PASS_WORD) begin
                w_all_pass = 1'b0;
            end
        end
    end

    // Verdict registers, captured once on the RUN->DONE edge and held until reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
            r_fail_core   <= '0;
            r_fail_status <= '0;
        end else if (w_go_done) begin
            r_done        <= 1'b1;
            r_pass        <= ~w_fail & ~w_timeout_hit & w_all_pass;
            r_fail        <= w_fail;
            r_timeout     <= w_timeout_hit;
            r_fail_core   <= w_fail_core;
            r_fail_status <= w_fail_status;
        end
    end

    // Host readout mux; indices beyond the core count read as zero
    always_comb begin
        stat_inst   = '0;
        stat_status = '0;
        for (int i = 0; i < P_NUM_CORES; i++) begin
            if (stat_sel == c_CORE_IDX_W'(i)) begin
                stat_inst   = w_inst[i];
                stat_status = w_status[i];
            end
        end
    end

    assign rst_out     = r_rst_chain;
    assign running     = w_run;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign fail_core   = r_fail_core;
    assign fail_status = r_fail_status;
    assign stat_cycles = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_riscv_sim_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_sim_monitor
// Brief    : Directed self-checking bench for riscv_sim_monitor (4 cores,
//            32-bit counters and status, 2 reset stages).
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_sim_monitor;

    localparam int NC = 4;
    localparam int CW = 32;
    localparam int SW = 32;
    localparam int RS = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [CW-1:0]     max_cycles;
    logic [NC*SW-1:0]  core_status;
    logic [NC-1:0]     inst_commit;
    logic [RS-1:0]     rst_out;
    logic              running;
    logic              done;
    logic              pass;
    logic              fail;
    logic              timeout;
    logic [2:0]        fail_core;
    logic [SW-1:0]     fail_status;
    logic [2:0]        stat_sel;
    logic [CW-1:0]     stat_cycles;
    logic [CW-1:0]     stat_inst;
    logic [SW-1:0]     stat_status;

    int checks = 0;
    int errors = 0;

    riscv_sim_monitor #(
        .P_NUM_CORES  (NC),
        .P_CNT_SZ     (CW),
        .P_STATUS_SZ  (SW),
        .P_RST_STAGES (RS)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .max_cycles  (max_cycles),
        .core_status (core_status),
        .inst_commit (inst_commit),
        .rst_out     (rst_out),
        .running     (running),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .fail_core   (fail_core),
        .fail_status (fail_status),
        .stat_sel    (stat_sel),
        .stat_cycles (stat_cycles),
        .stat_inst   (stat_inst),
        .stat_status (stat_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_status(input int idx, input logic [SW-1:0] val);
        core_status[idx*SW +: SW] = val;
    endtask

    task automatic sel(input logic [2:0] idx);
        stat_sel = idx;
        #1;
    endtask

    task automatic apply_reset();
        reset_n     = 1'b0;
        core_status = '0;
        inst_commit = '0;
        stat_sel    = 3'd0;
        step();
        step();
    endtask

    task automatic release_to_run(input string tag);
        reset_n = 1'b1;
        step();
        step();
        step();
        check(tag, running, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        max_cycles = 100;
        apply_reset();
        check("rst_rst_out", rst_out, 2'b11);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail, 0);
        check("rst_timeout", timeout, 0);
        check("rst_fail_core", fail_core, 0);
        check("rst_fail_status", fail_status, 0);
        check("rst_cycles", stat_cycles, 0);
        check("rst_inst", stat_inst, 0);
        check("rst_status", stat_status, 0);

        // Reset chain release
        reset_n = 1'b1;
        step();
        check("chain_stage0_fall", rst_out, 2'b10);
        check("chain_not_running1", running, 0);
        step();
        check("chain_stage1_fall", rst_out, 2'b00);
        check("chain_not_running2", running, 0);
        step();
        check("chain_running", running, 1);
        check("chain_cycles0", stat_cycles, 0);

        // Core 0 passes at RUN cycle 20 with 15 commits; others pass immediately
        for (int n = 0; n <= 20; n++) begin
            inst_commit = '0;
            if (n < 15) inst_commit[0] = 1'b1;
            if (n < 2)  inst_commit[1] = 1'b1;
            if (n == 0) begin
                set_status(1, 1);
                set_status(2, 1);
                set_status(3, 1);
            end
            if (n == 20) begin
                check("t1_not_done_early", done, 0);
                check("t1_cycles_pre", stat_cycles, 20);
                set_status(0, 1);
            end
            step();
        end
        inst_commit = '0;
        check("t1_done", done, 1);
        check("t1_pass", pass, 1);
        check("t1_fail", fail, 0);
        check("t1_timeout", timeout, 0);
        check("t1_running", running, 0);
        check("t1_cycles", stat_cycles, 21);
        sel(3'd0);
        check("t1_inst0", stat_inst, 15);
        check("t1_status0", stat_status, 1);
        sel(3'd1);
        check("t1_inst1_commit_with_status", stat_inst, 1);
        inst_commit = '1;
        step();
        step();
        inst_commit = '0;
        sel(3'd0);
        check("t1_cycles_frozen", stat_cycles, 21);
        check("t1_inst_frozen", stat_inst, 15);
        check("t1_done_sticky", done, 1);

        // Four cores, core 2 fails with 7, staggered finishes; status in RST ignored
        apply_reset();
        max_cycles = 100;
        set_status(0, 5);
        release_to_run("t3_running");
        set_status(0, 0);
        for (int n = 0; n <= 12; n++) begin
            if (n == 2)  set_status(0, 1);
            if (n == 5)  set_status(1, 1);
            if (n == 8)  set_status(2, 7);
            if (n == 9)  set_status(0, 9);
            if (n == 12) begin
                check("t3_not_done_early", done, 0);
                set_status(3, 1);
            end
            step();
        end
        check("t3_done", done, 1);
        check("t3_fail", fail, 1);
        check("t3_fail_core", fail_core, 2);
        check("t3_fail_status", fail_status, 7);
        check("t3_pass", pass, 0);
        check("t3_timeout", timeout, 0);
        check("t3_cycles", stat_cycles, 13);
        sel(3'd0);
        check("t3_status0_latched", stat_status, 1);
        sel(3'd2);
        check("t3_status2", stat_status, 7);
        sel(3'd5);
        check("t3_sel5_inst", stat_inst, 0);
        check("t3_sel5_status", stat_status, 0);
        sel(3'd0);

        // Timeout at 50 with core 1 never finishing; core 3 failed with 2
        apply_reset();
        max_cycles = 50;
        release_to_run("t4_running");
        for (int n = 0; n <= 50; n++) begin
            if (n == 0) begin
                set_status(0, 1);
                set_status(2, 1);
                set_status(3, 2);
            end
            if (n == 50) begin
                check("t4_not_done_early", done, 0);
                check("t4_cycles_pre", stat_cycles, 50);
            end
            step();
        end
        check("t4_done", done, 1);
        check("t4_timeout", timeout, 1);
        check("t4_pass", pass, 0);
        check("t4_fail", fail, 1);
        check("t4_fail_core", fail_core, 3);
        check("t4_fail_status", fail_status, 2);
        check("t4_cycles", stat_cycles, 50);
        step();
        step();
        check("t4_cycles_frozen", stat_cycles, 50);
        check("t4_done_sticky", done, 1);

        // Last core finishes on the cycle the limit is reached: completion wins
        apply_reset();
        max_cycles = 50;
        release_to_run("t5_running");
        for (int n = 0; n <= 50; n++) begin
            if (n == 0) begin
                set_status(1, 1);
                set_status(2, 1);
                set_status(3, 1);
            end
            if (n == 50) begin
                check("t5_not_done_early", done, 0);
                set_status(0, 1);
            end
            step();
        end
        check("t5_done", done, 1);
        check("t5_timeout", timeout, 0);
        check("t5_pass", pass, 1);
        check("t5_fail", fail, 0);

        // Timeout disabled, then reset dropped mid-RUN
        apply_reset();
        max_cycles = 0;
        release_to_run("t6_running");
        for (int n = 0; n < 10; n++) begin
            inst_commit = 4'b0001;
            if (n == 3) set_status(2, 4);
            step();
        end
        inst_commit = '0;
        check("t6_cycles_pre", stat_cycles, 10);
        check("t6_still_running", running, 1);
        sel(3'd0);
        check("t6_inst0_pre", stat_inst, 10);
        sel(3'd2);
        check("t6_status2_pre", stat_status, 4);
        reset_n = 1'b0;
        step();
        check("t6_rst_out", rst_out, 2'b11);
        check("t6_running", running, 0);
        check("t6_done", done, 0);
        check("t6_cycles", stat_cycles, 0);
        check("t6_status2", stat_status, 0);
        sel(3'd0);
        check("t6_inst0", stat_inst, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
